y_out_collect: RTL and testbench

// Sink end of the y-output stream. Takes the valid-only result stream of the fp16 y adder
// (y = ytmp + xD, fixed ADD_LAT, no backpressure), buffers it, and re-emits it to the y

---
 rtl/y_out_collect.sv | 137 +++++++++++++
 tb/tb_y_out_collect.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/y_out_collect.sv
// Output collector for the fp16 y adder: FWFT buffer with a credit guard on the
// non-stallable adder, re-emitting results over valid/ready with (h, p, last) tags.
//
// state    | meaning
// ST_FLUSH | post-reset drain of stale adder results, no credit
// ST_RUN   | normal operation, credit from inflight + count
module y_out_collect #(
  parameter int DW      = 16,
  parameter int ADD_LAT = 11,
  parameter int DEPTH   = 32,
  parameter int H       = 24,
  parameter int P       = 64,
  localparam int HW     = (H > 1) ? $clog2(H) : 1,
  localparam int PW     = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue_i,
  output logic          credit_o,
  input  logic          valid_i,
  input  logic [DW-1:0] y_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic [HW-1:0] m_h_o,
  output logic [PW-1:0] m_p_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic          err_o
);

  localparam logic [0:0] ST_FLUSH = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 2;
  localparam int FW = $clog2(ADD_LAT + 1) + 1;

  logic [0:0]    state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [IW-1:0] infl_q, infl_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [HW-1:0] h_q, h_d;
  logic [PW-1:0] p_q, p_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          run, rd_en, wr_en;
  logic [IW:0]   occ;

  assign run   = (state_q == ST_RUN);
  assign occ   = {1'b0, infl_q} + {{(IW - AW){1'b0}}, count_q};
  assign rd_en = (count_q != '0) && m_ready_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = run && valid_i && ((count_q < (AW + 1)'(DEPTH)) || rd_en);

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    infl_d  = infl_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    h_d     = h_q;
    p_d     = p_q;
    err_d   = err_q;

    case (state_q)
      ST_FLUSH: begin
        if (flush_q == FW'(ADD_LAT)) state_d = ST_RUN;
        flush_d = flush_q + 1'b1;
        if (issue_i) err_d = 1'b1;
      end
      ST_RUN: begin
        if (issue_i && !credit_o)           err_d = 1'b1;
        if (valid_i && (infl_q == '0))      err_d = 1'b1;
        if (valid_i && !wr_en)              err_d = 1'b1;
        if (issue_i && !valid_i && (infl_q != {IW{1'b1}}))
          infl_d = infl_q + 1'b1;
        else if (valid_i && !issue_i && (infl_q != '0))
          infl_d = infl_q - 1'b1;
      end
      default: state_d = ST_FLUSH;
    endcase

    if (wr_en) wr_d = wr_q + 1'b1;
    if (rd_en) rd_d = rd_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;

    if (rd_en) begin
      if (p_q == PW'(P - 1)) begin
        p_d = '0;
        h_d = (h_q == HW'(H - 1)) ? '0 : h_q + 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FLUSH;
      flush_q <= '0;
      infl_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      h_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      infl_q  <= infl_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      h_q     <= h_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= y_i;
  end

  assign credit_o  = run && (occ < (IW + 1)'(DEPTH));
  assign m_valid_o = (count_q != '0);
  assign m_data_o  = mem_q[rd_q];
  assign m_h_o     = h_q;
  assign m_p_o     = p_q;
  assign m_last_o  = m_valid_o && (h_q == HW'(H - 1)) && (p_q == PW'(P - 1));
  assign err_o     = err_q;

endmodule

// File: tb/tb_y_out_collect.sv
// Bench for y_out_collect: directed scenarios plus random traffic, checked by a
// queue-based reference model sampled on the falling clock edge.
module tb_y_out_collect;
  localparam int DW = 16, LAT = 3, DEPTH = 8, H = 2, P = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          issue_i = 1'b0, valid_i = 1'b0, m_ready_i = 1'b0;
  logic [DW-1:0] y_i = '0;
  logic          credit_o, m_valid_o, m_last_o, err_o;
  logic [DW-1:0] m_data_o;
  logic [0:0]    m_h_o;
  logic [1:0]    m_p_o;

  y_out_collect #(.DW(DW), .ADD_LAT(LAT), .DEPTH(DEPTH), .H(H), .P(P)) dut (
    .clk(clk), .rstn(rstn), .issue_i(issue_i), .credit_o(credit_o),
    .valid_i(valid_i), .y_i(y_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_h_o(m_h_o), .m_p_o(m_p_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents, element index, credit and sticky error.
  logic [DW-1:0] sb[$];
  int            k_m = 0;
  int            infl_m = 0;
  int            flush_left = LAT + 1;
  bit            err_m = 1'b0;

  always @(negedge clk) begin
    bit rd, run, cr;
    if (!rstn) begin
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_credit", credit_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_last", m_last_o, 0);
      sb.delete();
      k_m = 0; infl_m = 0; flush_left = LAT + 1; err_m = 1'b0;
    end else begin
      run = (flush_left == 0);
      cr  = run && ((infl_m + sb.size()) < DEPTH);
      chk("m_valid", m_valid_o, sb.size() != 0);
      chk("credit", credit_o, cr);
      chk("err", err_o, err_m);
      if (sb.size() != 0) begin
        chk("data", m_data_o, sb[0]);
        chk("h_idx", m_h_o, (k_m / P) % H);
        chk("p_idx", m_p_o, k_m % P);
        chk("last", m_last_o, (k_m % (H * P)) == (H * P - 1));
      end else begin
        chk("last_idle", m_last_o, 0);
      end
      rd = (sb.size() != 0) && m_ready_i;
      if (!run) begin
        if (issue_i) err_m = 1'b1;
      end else begin
        if (issue_i && !cr) err_m = 1'b1;
        if (valid_i && infl_m == 0) err_m = 1'b1;
        if (issue_i && !valid_i) infl_m++;
        else if (valid_i && !issue_i && infl_m > 0) infl_m--;
        if (valid_i) begin
          if (sb.size() < DEPTH || rd) sb.push_back(y_i);
          else err_m = 1'b1;
        end
      end
      if (rd) begin
        void'(sb.pop_front());
        k_m++;
      end
      if (flush_left > 0) flush_left--;
    end
  end

  // Behavioural adder: fixed-latency delay line from issue_i to valid_i.
  bit            pv[LAT];
  logic [DW-1:0] pd[LAT];

  task automatic cyc(input bit iss, input logic [DW-1:0] d, input bit rdy,
                     input bit stray = 1'b0, input logic [DW-1:0] sd = '0);
    valid_i = pv[0] | stray;
    y_i     = stray ? sd : pd[0];
    for (int i = 0; i < LAT - 1; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[LAT-1] = iss;
    pd[LAT-1] = d;
    issue_i   = iss;
    m_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; issue_i = 1'b0; valid_i = 1'b0; m_ready_i = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    #1;
    chk("reset_m_valid_now", m_valid_o, 0);
    chk("reset_credit_now", credit_o, 0);
    chk("reset_err_now", err_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    bit c, iss, rdy;
    #2;
    do_reset();

    // Flush window: stale results discarded, no credit for LAT+1 cycles.
    for (int i = 0; i < LAT + 1; i++) begin
      chk("flush_credit", credit_o, 0);
      cyc(1'b0, '0, 1'b1, 1'b1, 16'h3C00);
    end
    chk("post_flush_credit", credit_o, 1);
    chk("post_flush_empty", m_valid_o, 0);
    chk("post_flush_err", err_o, 0);

    // Full frame, streaming.
    for (int i = 0; i < H * P; i++) cyc(1'b1, 16'h4000 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    chk("frame_err", err_o, 0);
    chk("frame_drained", m_valid_o, 0);

    // Stray result with nothing in flight.
    cyc(1'b0, '0, 1'b0, 1'b1, 16'h5555);
    cyc(1'b0, '0, 1'b0);
    chk("stray_err", err_o, 1);
    chk("stray_stored", m_valid_o, 1);
    chk("stray_data", m_data_o, 16'h5555);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    // Credit exhaustion with a stalled sink, then forced overrun.
    do_reset();
    n = 0;
    for (int i = 0; i < 24; i++) begin
      c = credit_o;
      if (c) n++;
      cyc(c, 16'($urandom), 1'b0);
    end
    chk("credit_issues", n, DEPTH);
    chk("credit_exhausted", credit_o, 0);
    chk("credit_err_clean", err_o, 0);
    cyc(1'b1, 16'hABCD, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("forced_issue_err", err_o, 1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("full_simul_valid", m_valid_o, 1);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);
    chk("full_simul_drained", m_valid_o, 0);

    // Reset mid-frame with data still buffered.
    do_reset();
    for (int i = 0; i < LAT + 1; i++) cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0);
    chk("midframe_buffered", m_valid_o, 1);
    do_reset();
    for (int i = 0; i < LAT + 1; i++) cyc(1'b0, '0, 1'b0);

    // Random traffic, issuing only under credit.
    for (int i = 0; i < 600; i++) begin
      c   = credit_o;
      iss = c && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(iss, 16'($urandom), rdy);
    end
    for (int i = 0; i < 24; i++) cyc(1'b0, '0, 1'b1);
    chk("random_err", err_o, 0);
    chk("random_drained", m_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
